scal_fac_adap: RTL and testbench

SCAL_FAC_ADAP -- requirements
Module: scal_fac_adap

---
 rtl/adpcm_pkg.sv | 59 +++++
 rtl/functw.sv | 29 ++
 rtl/scal_fac_adap.sv | 181 ++++++++++++++++++
 tb/tb_scal_fac_adap.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_pkg.sv
// Shared ADPCM definitions: rate encodings, W(I) tables, scale-factor limits,
// reset values and the scale-factor adaptation FSM state type.
package adpcm_pkg;

    // RATE field encodings (codeword width follows the rate)
    localparam logic [1:0] RATE_16 = 2'b11;   // 2-bit codewords
    localparam logic [1:0] RATE_24 = 2'b10;   // 3-bit codewords
    localparam logic [1:0] RATE_32 = 2'b01;   // 4-bit codewords
    localparam logic [1:0] RATE_40 = 2'b00;   // 5-bit codewords

    // Datapath widths
    localparam int YU_W   = 13;   // fast scale factor / quantizer scale factor
    localparam int YL_W   = 19;   // slow scale factor (YU with 6 fraction bits)
    localparam int WI_W   = 12;   // W(I) table entries, two's complement
    localparam int AL_W   = 7;    // speed-control parameter 0..64
    localparam int DIF_W  = 14;   // signed YU - (YL>>6)
    localparam int PROD_W = 20;   // |DIF| * AL before the >>6

    // Fast scale factor limits and reset values
    localparam logic [YU_W-1:0] YU_MIN      = 13'd544;
    localparam logic [YU_W-1:0] YU_MAX      = 13'd5120;
    localparam logic [YU_W-1:0] YU_RST_DFLT = 13'd544;
    localparam logic [YL_W-1:0] YL_RST_DFLT = 19'd34816;
    localparam logic [YU_W-1:0] Y_RST       = 13'd544;

    // Speed-control parameter ceiling
    localparam logic [AL_W-1:0] AL_MAX = 7'd64;

    // Serial multiplier: one AL bit per MIX cycle
    localparam int             MIX_CYCLES = AL_W;
    localparam logic [2:0]     MIX_LAST   = 3'(MIX_CYCLES - 1);

    // W(I) tables indexed by codeword magnitude
    localparam logic signed [WI_W-1:0] W16_TAB [0:1] = '{
        -12'sd22, 12'sd439
    };
    localparam logic signed [WI_W-1:0] W24_TAB [0:3] = '{
        -12'sd4, 12'sd30, 12'sd137, 12'sd582
    };
    localparam logic signed [WI_W-1:0] W32_TAB [0:7] = '{
        -12'sd12, 12'sd18, 12'sd41, 12'sd64,
         12'sd112, 12'sd198, 12'sd355, 12'sd1122
    };
    localparam logic signed [WI_W-1:0] W40_TAB [0:15] = '{
        12'sd14,  12'sd14,  12'sd24,  12'sd39,
        12'sd40,  12'sd41,  12'sd58,  12'sd100,
        12'sd141, 12'sd179, 12'sd219, 12'sd280,
        12'sd358, 12'sd440, 12'sd529, 12'sd696
    };

    // Scale-factor adaptation sequencing
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } sfa_state_t;

endpackage

// File: rtl/functw.sv
// W(I) lookup: maps an ADPCM codeword to its log-domain scale-factor weight.
module functw
    import adpcm_pkg::*;
(
    input  logic [1:0]             RATE,
    input  logic [4:0]             I,
    output logic signed [WI_W-1:0] WI
);

    logic       mag16;
    logic [1:0] mag24;
    logic [2:0] mag32;
    logic [3:0] mag40;

    // Fold the sign bit away (negative codes invert the rest), then pick the rate's table
    always_comb begin
        mag16 = I[1] ? ~I[0]   : I[0];
        mag24 = I[2] ? ~I[1:0] : I[1:0];
        mag32 = I[3] ? ~I[2:0] : I[2:0];
        mag40 = I[4] ? ~I[3:0] : I[3:0];
        case (RATE)
            RATE_16: WI = W16_TAB[mag16];
            RATE_24: WI = W24_TAB[mag24];
            RATE_32: WI = W32_TAB[mag32];
            default: WI = W40_TAB[mag40];
        endcase
    end

endmodule

// File: rtl/scal_fac_adap.sv
// Quantizer scale factor adaptation: updates the fast (YU) and slow (YL)
// scale factors from a captured codeword, then mixes them with AL using a
// 7-cycle serial shift-add multiplier and registers the result on Y.
module scal_fac_adap
    import adpcm_pkg::*;
#(
    parameter logic [YU_W-1:0] YU_RST = YU_RST_DFLT,
    parameter logic [YL_W-1:0] YL_RST = YL_RST_DFLT
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            STB,
    input  logic [4:0]      I,
    input  logic [1:0]      RATE,
    input  logic [AL_W-1:0] AL,
    output logic [YU_W-1:0] Y,
    output logic            Y_VALID,
    output logic            BUSY,
    input  logic            scan_enable,
    input  logic            scan_in0,
    input  logic            scan_in1,
    input  logic            scan_in2,
    input  logic            scan_in3,
    input  logic            scan_in4,
    output logic            scan_out0,
    output logic            scan_out1,
    output logic            scan_out2,
    output logic            scan_out3,
    output logic            scan_out4
);

    // Control
    sfa_state_t state, state_nxt;
    logic       accept;
    logic [2:0] mix_cnt;

    // Captured transaction (stage 0)
    logic [4:0]      i_p0;
    logic [1:0]      rate_p0;
    logic [AL_W-1:0] al_p0;

    // Scale factor state and update path
    logic signed [WI_W-1:0]  wi;
    logic [YU_W-1:0]         yu;
    logic [YL_W-1:0]         yl;
    logic signed [16:0]      dyu;
    logic [YU_W-1:0]         yut;
    logic [YU_W-1:0]         yup;
    logic signed [YL_W:0]    dyl;
    logic [YL_W-1:0]         yl_nxt;
    logic signed [DIF_W-1:0] dif;
    logic [DIF_W-1:0]        dif_mag;

    // Serial multiplier (stage 1)
    logic [PROD_W-1:0] mcand_p1;
    logic [PROD_W-1:0] prod_p1;
    logic [AL_W-1:0]   mplier_p1;
    logic              neg_p1;

    // Final mix
    logic [YU_W-1:0] prod_sh;
    logic [YU_W-1:0] y_new;

    logic unused_scan;

    function automatic logic [YU_W-1:0] sat_yu(input logic [YU_W-1:0] v);
        if (v < YU_MIN)
            return YU_MIN;
        else if (v > YU_MAX)
            return YU_MAX;
        else
            return v;
    endfunction

    function automatic logic [AL_W-1:0] sat_al(input logic [AL_W-1:0] v);
        return (v > AL_MAX) ? AL_MAX : v;
    endfunction

    function automatic logic [DIF_W-1:0] abs_dif(input logic signed [DIF_W-1:0] v);
        return v[DIF_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Scan chain hooks are stitched in later; until then the outputs are tied low
    assign scan_out0   = 1'b0;
    assign scan_out1   = 1'b0;
    assign scan_out2   = 1'b0;
    assign scan_out3   = 1'b0;
    assign scan_out4   = 1'b0;
    assign unused_scan = ^{scan_enable, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4};

    functw u_functw (
        .RATE (rate_p0),
        .I    (i_p0),
        .WI   (wi)
    );

    // FSM state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state; STB is only honoured in IDLE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        BUSY      = (state != IDLE) || Y_VALID;
        case (state)
            IDLE: begin
                if (STB) begin
                    accept    = 1'b1;
                    state_nxt = UPD;
                end
            end
            UPD:     state_nxt = MIX;
            MIX:     if (mix_cnt == MIX_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 0 -> 1: YU/YL update arithmetic and the signed difference of the new values
    always_comb begin
        dyu     = $signed({wi, 5'b0}) - $signed({4'b0, Y});
        yut     = Y + YU_W'(dyu >>> 5);
        yup     = sat_yu(yut);
        dyl     = $signed({1'b0, yup, 6'b0}) - $signed({1'b0, yl});
        yl_nxt  = yl + YL_W'(dyl >>> 6);
        dif     = $signed({1'b0, yup}) - $signed({1'b0, yl_nxt[YL_W-1:6]});
        dif_mag = abs_dif(dif);
    end

    // Stage 1 -> out: apply the signed product to the integer part of YL
    always_comb begin
        prod_sh = YU_W'(prod_p1 >> 6);
        y_new   = neg_p1 ? (yl[YL_W-1:6] - prod_sh) : (yl[YL_W-1:6] + prod_sh);
    end

    // Architectural state: MIX step counter, scale factors, output and its valid pulse
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mix_cnt <= '0;
            yu      <= YU_RST;
            yl      <= YL_RST;
            Y       <= Y_RST;
            Y_VALID <= 1'b0;
        end else begin
            mix_cnt <= (state == MIX) ? mix_cnt + 3'd1 : 3'd0;
            Y_VALID <= (state == DONE);
            if (state == UPD) begin
                yu <= yup;
                yl <= yl_nxt;
            end
            if (state == DONE)
                Y <= y_new;
        end
    end

    // Datapath registers: capture on accept, load the multiplier in UPD, shift-add in MIX
    always_ff @(posedge CLK) begin
        if (accept) begin
            i_p0    <= I;
            rate_p0 <= RATE;
            al_p0   <= sat_al(AL);
        end
        if (state == UPD) begin
            mcand_p1  <= PROD_W'(dif_mag);
            mplier_p1 <= al_p0;
            prod_p1   <= '0;
            neg_p1    <= dif[DIF_W-1];
        end else if (state == MIX) begin
            if (mplier_p1[0])
                prod_p1 <= prod_p1 + mcand_p1;
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
        end
    end

endmodule

// File: tb/tb_scal_fac_adap.sv
// Directed testbench for scal_fac_adap with hand-computed expected values.
module tb_scal_fac_adap;

    logic        CLK;
    logic        reset;
    logic        STB;
    logic [4:0]  I;
    logic [1:0]  RATE;
    logic [6:0]  AL;
    logic [12:0] Y;
    logic        Y_VALID;
    logic        BUSY;
    logic        scan_enable;
    logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    int n_cmp;
    int n_err;

    scal_fac_adap dut (
        .CLK         (CLK),
        .reset       (reset),
        .STB         (STB),
        .I           (I),
        .RATE        (RATE),
        .AL          (AL),
        .Y           (Y),
        .Y_VALID     (Y_VALID),
        .BUSY        (BUSY),
        .scan_enable (scan_enable),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Hold reset across two rising edges, return at a falling edge
    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        STB   = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
    endtask

    // Strobe one transaction (called at a falling edge), scramble inputs after
    // capture, and count rising edges until Y_VALID is seen
    task automatic run_op(input logic [1:0] rate, input logic [4:0] code,
                          input logic [6:0] al, output int lat);
        STB  = 1'b1;
        RATE = rate;
        I    = code;
        AL   = al;
        @(negedge CLK);
        STB  = 1'b0;
        RATE = ~rate;
        I    = ~code;
        AL   = ~al;
        lat  = 0;
        while (!Y_VALID && lat < 30) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic op(input string tag, input logic [1:0] rate, input logic [4:0] code,
                      input logic [6:0] al, input int exp_y, input int exp_yu, input int exp_yl);
        int lat;
        run_op(rate, code, al, lat);
        check({tag, "_lat"},  32'(lat),    9);
        check({tag, "_y"},    32'(Y),      exp_y);
        check({tag, "_yu"},   32'(dut.yu), exp_yu);
        check({tag, "_yl"},   32'(dut.yl), exp_yl);
        check({tag, "_busy"}, 32'(BUSY),   1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int exp_y;
        int n_vld;
        int first;
        int y_at;
        int sat_tab [4] = '{1649, 2719, 3756, 4760};

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        STB   = 1'b0;
        I     = '0;
        RATE  = '0;
        AL    = '0;
        scan_enable = 1'b0;
        scan_in0 = 1'b0; scan_in1 = 1'b0; scan_in2 = 1'b0; scan_in3 = 1'b0; scan_in4 = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);

        // Reset state
        check("rst_y",    32'(Y),       544);
        check("rst_busy", 32'(BUSY),    0);
        check("rst_vld",  32'(Y_VALID), 0);
        check("rst_yu",   32'(dut.yu),  544);
        check("rst_yl",   32'(dut.yl),  34816);
        check("scan_out", 32'({scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}), 0);

        // WI = -12 pulls YUT below the floor
        op("zero_wi", 2'b01, 5'd0, 7'd0, 544, 544, 34816);
        @(negedge CLK);
        check("vld_pulse", 32'(Y_VALID), 0);
        check("busy_idle", 32'(BUSY),    0);
        check("y_hold",    32'(Y),       544);

        // Chained directed sequence across all rates, back to back
        do_reset();
        op("w1122",   2'b01, 5'd7,       7'd0,   561,  1649, 35921);
        op("neg_dif", 2'b01, 5'd0,       7'd32,  552,  544,  35903);
        op("r16",     2'b11, 5'b00001,   7'd100, 973,  973,  36315);
        op("r24",     2'b10, 5'b00110,   7'd1,   579,  972,  36719);
        op("r40",     2'b00, 5'b01111,   7'd64,  1256, 1256, 37401);

        // Full speed-control weight, and AL above 64
        do_reset();
        op("al64",  2'b01, 5'd7, 7'd64,  1649, 1649, 35921);
        do_reset();
        op("al100", 2'b01, 5'd7, 7'd100, 1649, 1649, 35921);

        // Back-to-back strobes drive YU into the ceiling
        do_reset();
        for (int k = 0; k < 40; k++) begin
            run_op(2'b01, 5'd7, 7'd64, lat);
            exp_y = (k < 4) ? sat_tab[k] : 5120;
            check("b2b_lat", 32'(lat),    9);
            check("b2b_y",   32'(Y),      exp_y);
            check("b2b_yu",  32'(dut.yu), exp_y);
        end

        // STB during MIX must be ignored
        do_reset();
        STB  = 1'b1;
        RATE = 2'b01;
        I    = 5'd7;
        AL   = 7'd0;
        @(negedge CLK);
        STB = 1'b0;
        I   = 5'd0;
        AL  = 7'd64;
        repeat (3) @(negedge CLK);
        STB = 1'b1;
        repeat (2) @(negedge CLK);
        STB   = 1'b0;
        n_vld = 0;
        first = 0;
        y_at  = 0;
        for (int c = 6; c <= 25; c++) begin
            @(negedge CLK);
            if (Y_VALID) begin
                n_vld++;
                if (n_vld == 1) begin
                    first = c;
                    y_at  = 32'(Y);
                end
            end
        end
        check("mix_stb_pulses", 32'(n_vld), 1);
        check("mix_stb_lat",    32'(first), 9);
        check("mix_stb_y",      32'(y_at),  561);

        // Reset asserted in the middle of MIX
        STB  = 1'b1;
        RATE = 2'b01;
        I    = 5'd7;
        AL   = 7'd64;
        @(negedge CLK);
        STB = 1'b0;
        repeat (3) @(negedge CLK);
        check("mid_busy_pre", 32'(BUSY), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_y",    32'(Y),       544);
        check("mid_rst_busy", 32'(BUSY),    0);
        check("mid_rst_vld",  32'(Y_VALID), 0);
        check("mid_rst_yu",   32'(dut.yu),  544);
        check("mid_rst_yl",   32'(dut.yl),  34816);
        @(negedge CLK);
        reset = 1'b0;
        n_vld = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            if (Y_VALID) n_vld++;
        end
        check("mid_rst_novld", 32'(n_vld), 0);
        check("mid_rst_yhold", 32'(Y),     544);

        // Normal operation resumes after the aborted transaction
        op("post_rst", 2'b01, 5'd7, 7'd0, 561, 1649, 35921);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
